// File: rtl/alarm_annunciator.sv
// Operator-side alarm annunciator: persistence filtering, sticky latching, buzzer/escalation FSM
// and a per-channel event queue carrying the pwr_reg snapshot taken at latch time.
//
// state     | meaning
// S_IDLE    | no unacknowledged alarm, buzzer off
// S_ALERT   | new alarm latched, buzzer on, escalation timer running
// S_ESC     | no ack within ESC_CYCLES edges, buzzer and escalate on
// S_ACKED   | operator acknowledged, latched bits release as raw bits drop
module alarm_annunciator #(
  parameter int PERSIST    = 3,
  parameter int ESC_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] alarm_leds,
  input  logic [3:0] pwr_reg,
  input  logic       ack,
  input  logic       evt_ready,
  output logic [2:0] latched,
  output logic       buzzer,
  output logic       escalate,
  output logic       evt_valid,
  output logic [1:0] evt_chan,
  output logic [3:0] evt_pwr,
  output logic [7:0] alarm_count
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam int TW = $clog2(ESC_CYCLES + 1);
  localparam logic [CW-1:0] PMAX  = CW'(PERSIST);
  localparam logic [CW-1:0] PHIGH = CW'(PERSIST - 1);
  localparam logic [TW-1:0] TLAST = TW'(ESC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALERT = 2'd1,
    S_ESC   = 2'd2,
    S_ACKED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   pcnt_q [3];
  logic [CW-1:0]   pcnt_d [3];
  logic [3:0]      snap_q [3];
  logic [3:0]      snap_d [3];
  logic [2:0]      latched_q, latched_d;
  logic [2:0]      pend_q, pend_d;
  logic [7:0]      count_q, count_d;
  logic            hold_q, hold_d;
  logic [1:0]      hold_chan_q, hold_chan_d;

  logic [2:0]      latch_mask;
  logic [2:0]      clr_mask;
  logic [2:0]      xfer_mask;
  logic            any_latch;
  logic            xfer;
  logic [1:0]      head_chan;
  logic [1:0]      present_chan;
  logic [8:0]      cnt_sum;

  // Persistence counters and latch qualification
  always_comb begin
    latch_mask = '0;
    for (int i = 0; i < 3; i++) begin
      pcnt_d[i] = '0;
      if (alarm_leds[i]) begin
        pcnt_d[i] = (pcnt_q[i] == PMAX) ? PMAX : pcnt_q[i] + CW'(1);
        latch_mask[i] = (pcnt_q[i] >= PHIGH) && !latched_q[i];
      end
    end
  end

  assign any_latch = |latch_mask;

  // Lowest pending channel, frozen once presented until it transfers
  always_comb begin
    head_chan = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (pend_q[i]) head_chan = 2'(i);
    end
  end

  assign present_chan = hold_q ? hold_chan_q : head_chan;
  assign evt_valid    = |pend_q;
  assign evt_chan     = present_chan;
  assign evt_pwr      = evt_valid ? snap_q[present_chan] : 4'd0;
  assign xfer         = evt_valid && evt_ready;
  assign xfer_mask    = xfer ? (3'b001 << present_chan) : 3'b000;

  always_comb begin
    pend_d      = (pend_q & ~xfer_mask) | latch_mask;
    hold_d      = hold_q;
    hold_chan_d = hold_chan_q;
    if (xfer) begin
      hold_d      = 1'b0;
      hold_chan_d = 2'd0;
    end else if (evt_valid) begin
      hold_d      = 1'b1;
      hold_chan_d = present_chan;
    end
    for (int i = 0; i < 3; i++) begin
      snap_d[i] = latch_mask[i] ? pwr_reg : snap_q[i];
    end
  end

  always_comb begin
    cnt_sum = {1'b0, count_q} + 9'(latch_mask[0]) + 9'(latch_mask[1]) + 9'(latch_mask[2]);
    count_d = (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
  end

  assign clr_mask  = (state_q == S_ACKED) ? ~alarm_leds : 3'b000;
  assign latched_d = (latched_q & ~clr_mask) | latch_mask;

  // A latch always wins over a simultaneous ack and restarts the timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (any_latch) begin
          state_d = S_ALERT;
          timer_d = '0;
        end
      end
      S_ALERT: begin
        if (any_latch) begin
          timer_d = '0;
        end else if (ack) begin
          state_d = S_ACKED;
        end else if (timer_q == TLAST) begin
          state_d = S_ESC;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ESC: begin
        if (any_latch && ack) begin
          state_d = S_ALERT;
          timer_d = '0;
        end else if (ack) begin
          state_d = S_ACKED;
        end
      end
      S_ACKED: begin
        if (any_latch) begin
          state_d = S_ALERT;
          timer_d = '0;
        end else if (latched_d == 3'b000) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      latched_q   <= '0;
      pend_q      <= '0;
      count_q     <= '0;
      hold_q      <= 1'b0;
      hold_chan_q <= '0;
      for (int i = 0; i < 3; i++) begin
        pcnt_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      latched_q   <= latched_d;
      pend_q      <= pend_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      hold_chan_q <= hold_chan_d;
      for (int i = 0; i < 3; i++) begin
        pcnt_q[i] <= pcnt_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign latched     = latched_q;
  assign alarm_count = count_q;
  assign buzzer      = (state_q == S_ALERT) || (state_q == S_ESC);
  assign escalate    = (state_q == S_ESC);

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: per-edge vector table for all outputs plus an event
// scoreboard that checks every transfer against the expected channel/pwr snapshot.
module tb_alarm_annunciator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] alarm_leds = '0;
  logic [3:0] pwr_reg = '0;
  logic       ack = 1'b0;
  logic       evt_ready = 1'b0;
  logic [2:0] latched;
  logic       buzzer, escalate, evt_valid;
  logic [1:0] evt_chan;
  logic [3:0] evt_pwr;
  logic [7:0] alarm_count;

  int total = 0;
  int bad   = 0;

  alarm_annunciator #(.PERSIST(3), .ESC_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .alarm_leds(alarm_leds), .pwr_reg(pwr_reg),
    .ack(ack), .evt_ready(evt_ready), .latched(latched), .buzzer(buzzer),
    .escalate(escalate), .evt_valid(evt_valid), .evt_chan(evt_chan),
    .evt_pwr(evt_pwr), .alarm_count(alarm_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] leds;
    logic [3:0] pwr;
    logic       ack;
    logic       rdy;
    logic [2:0] lat;
    logic       buz;
    logic       esc;
    logic       vld;
    logic [1:0] ch;
    logic [3:0] ep;
    logic [7:0] cnt;
    logic [2:0] newev;
  } vec_t;

  vec_t       vq[$];
  logic [5:0] evq[$];

  task automatic v(input logic rst, input logic [2:0] leds, input logic [3:0] pwr,
                   input logic a, input logic rdy, input logic [2:0] lat, input logic buz,
                   input logic esc, input logic vld, input logic [1:0] ch,
                   input logic [3:0] ep, input logic [7:0] cnt, input logic [2:0] newev);
    vec_t r;
    r.rst = rst; r.leds = leds; r.pwr = pwr; r.ack = a; r.rdy = rdy;
    r.lat = lat; r.buz = buz; r.esc = esc; r.vld = vld; r.ch = ch; r.ep = ep;
    r.cnt = cnt; r.newev = newev;
    vq.push_back(r);
  endtask

  function automatic logic [19:0] pack_out();
    return {latched, buzzer, escalate, evt_valid, evt_chan, evt_pwr, alarm_count};
  endfunction

  task automatic check_out(input string name, input int step, input logic [19:0] want);
    logic [19:0] got;
    got = pack_out();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d: got lat/buz/esc/vld/ch/pwr/cnt=%h want %h", name, step, got, want);
    end
  endtask

  // Scoreboard: each transfer must match the oldest expected event
  always @(negedge clk) begin
    if (!rst_n && evt_valid && evt_ready) begin
      total++;
      if (evq.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected: got chan=%0d pwr=%h want no event", evt_chan, evt_pwr);
      end else begin
        logic [5:0] exp_ev;
        exp_ev = evq.pop_front();
        if ({evt_chan, evt_pwr} !== exp_ev) begin
          bad++;
          $display("FAIL evt_xfer: got chan=%0d pwr=%h want chan=%0d pwr=%h",
                   evt_chan, evt_pwr, exp_ev[5:4], exp_ev[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Glitch rejected
    v(0, 3'b001, 4'h0, 0, 0, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    v(0, 3'b001, 4'h0, 0, 0, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    v(0, 3'b000, 4'h0, 0, 0, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    // Latch on channel 1 under backpressure
    v(0, 3'b010, 4'hA, 0, 0, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    v(0, 3'b010, 4'hA, 0, 0, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    v(0, 3'b010, 4'hA, 0, 0, 3'b010, 1, 0, 1, 2'd1, 4'hA, 8'd1, 3'b010);
    for (int k = 0; k < 5; k++)
      v(0, 3'b010, 4'hA, 0, 0, 3'b010, 1, 0, 1, 2'd1, 4'hA, 8'd1, 3'b000);
    // Release backpressure, then wait for escalation 16 edges after the latch
    for (int k = 0; k < 10; k++)
      v(0, 3'b010, 4'hA, 0, 1, 3'b010, 1, 0, 0, 2'd0, 4'h0, 8'd1, 3'b000);
    v(0, 3'b010, 4'hA, 0, 1, 3'b010, 1, 1, 0, 2'd0, 4'h0, 8'd1, 3'b000);
    v(0, 3'b010, 4'hA, 1, 1, 3'b010, 0, 0, 0, 2'd0, 4'h0, 8'd1, 3'b000);
    v(0, 3'b010, 4'hA, 0, 1, 3'b010, 0, 0, 0, 2'd0, 4'h0, 8'd1, 3'b000);
    v(0, 3'b000, 4'hA, 0, 1, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd1, 3'b000);
    // Fresh reset, then three simultaneous latches drained one per edge
    v(1, 3'b111, 4'h5, 0, 1, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    v(0, 3'b111, 4'h5, 0, 1, 3'b000, 0, 0, 0, 2'd0, 4'h0, 8'd0, 3'b000);
    v(0, 3'b111, 4'h5, 0, 1, 3'b111, 1, 0, 1, 2'd0, 4'h5, 8'd3, 3'b111);
    v(0, 3'b111, 4'h5, 0, 1, 3'b111, 1, 0, 1, 2'd1, 4'h5, 8'd3, 3'b000);
    v(0, 3'b111, 4'h5, 0, 1, 3'b111, 1, 0, 1, 2'd2, 4'h5, 8'd3, 3'b000);
    v(0, 3'b111, 4'h5, 0, 1, 3'b111, 1, 0, 0, 2'd0, 4'h0, 8'd3, 3'b000);
    // Ack, partial release, then channel 2 latches on the same edge as ack
    v(0, 3'b111, 4'h5, 1, 1, 3'b111, 0, 0, 0, 2'd0, 4'h0, 8'd3, 3'b000);
    v(0, 3'b001, 4'h5, 0, 1, 3'b001, 0, 0, 0, 2'd0, 4'h0, 8'd3, 3'b000);
    v(0, 3'b101, 4'h5, 0, 1, 3'b001, 0, 0, 0, 2'd0, 4'h0, 8'd3, 3'b000);
    v(0, 3'b101, 4'h5, 0, 1, 3'b001, 0, 0, 0, 2'd0, 4'h0, 8'd3, 3'b000);
    v(0, 3'b101, 4'h3, 1, 0, 3'b101, 1, 0, 1, 2'd2, 4'h3, 8'd4, 3'b100);
    for (int k = 0; k < 15; k++)
      v(0, 3'b101, 4'h3, 0, 0, 3'b101, 1, 0, 1, 2'd2, 4'h3, 8'd4, 3'b000);
    v(0, 3'b101, 4'h3, 0, 0, 3'b101, 1, 1, 1, 2'd2, 4'h3, 8'd4, 3'b000);

    // Reset asserted at time zero: outputs must already be clear before any edge
    #1;
    check_out("reset_state", 0, 20'h0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int s = 0; s < vq.size(); s++) begin
      if (vq[s].rst) begin
        rst_n = 1'b1;
        evq.delete();
        #2;
        rst_n = 1'b0;
      end
      alarm_leds = vq[s].leds;
      pwr_reg    = vq[s].pwr;
      ack        = vq[s].ack;
      evt_ready  = vq[s].rdy;
      for (int c = 0; c < 3; c++)
        if (vq[s].newev[c]) evq.push_back({2'(c), vq[s].pwr});
      @(posedge clk);
      #1;
      check_out("vector", s + 1,
                {vq[s].lat, vq[s].buz, vq[s].esc, vq[s].vld, vq[s].ch, vq[s].ep, vq[s].cnt});
    end

    // Reset mid-ESCALATED with an event pending: clears between edges, nothing transfers
    #2;
    rst_n = 1'b1;
    evq.delete();
    #1;
    check_out("reset_async", 0, 20'h0);
    alarm_leds = 3'b000;
    ack        = 1'b0;
    @(posedge clk);
    #1;
    check_out("reset_held", 0, 20'h0);
    #2;
    rst_n = 1'b0;
    evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_out("post_reset_idle", k, 20'h0);
    end

    total++;
    if (evq.size() != 0) begin
      bad++;
      $display("FAIL evt_drain: got %0d events never transferred want 0", evq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
# alarm_annunciator

Operator-side responder for the alarm monitor. It consumes the monitor's `alarm_leds` and `pwr_reg` outputs and filters each alarm channel for persistence. Qualified alarms are latched and drive a buzzer/escalation state machine with an operator acknowledge. Each newly latched alarm is queued as an event (channel plus `pwr_reg` snapshot) on a valid/ready interface toward the logging/telemetry path.

## Interface
- `PERSIST`, default 3: consecutive sampled-high edges needed to qualify an alarm bit. Legal range ≥1.
- `ESC_CYCLES`, default 16: edges spent in ALERT without ack before escalation. Legal range ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-high. Asserted when `rst_n`=1.
- `alarm_leds` in 3: raw alarm bits from the monitor.
- `pwr_reg` in 4: monitor power register, snapshotted at latch time.
- `ack` in 1: operator acknowledge, sampled each edge as a level.
- `evt_ready` in 1: downstream ready for events.
- `latched` out 3: sticky qualified alarm bits.
- `buzzer` out 1: high in ALERT or ESCALATED.
- `escalate` out 1: high in ESCALATED only.
- `evt_valid` out 1: an event is pending.
- `evt_chan` out 2: channel index (0-2) of the presented event.
- `evt_pwr` out 4: `pwr_reg` snapshot for that channel.
- `alarm_count` out 8: total latch events, saturating at 255.

## Operation
- **Persistence counter.** One counter per channel i, width clog2(PERSIST+1).
  - `alarm_leds[i]`=0 → counter = 0.
  - Otherwise it increments, saturating at PERSIST.
- **Latch event.** Channel i latches on the edge where `alarm_leds[i]` has been sampled high on PERSIST consecutive edges, provided `latched[i]` was 0. On that edge:
  - `latched[i]` is set.
  - `pend[i]` is set.
  - `snap[i]` <= `pwr_reg`.
  - `alarm_count` increments by the number of channels latching that edge, saturating at 255.
- **Event queue.** Each channel has one pending slot.
  - `evt_valid` = |pend.
  - `evt_chan` = lowest set pend index; `evt_pwr` = `snap[evt_chan]`.
  - Transfer occurs on `evt_valid` && `evt_ready`, which clears that pend bit.
  - `evt_chan` and `evt_pwr` are held stable while `evt_valid` && !`evt_ready`.
  - A channel cannot re-latch while its pend bit is still set, because `latched[i]` stays 1.
- **FSM** states: IDLE, ALERT, ESCALATED, ACKED.
  - IDLE → ALERT on any latch event; timer is cleared.
  - ALERT: the timer increments each edge. It moves to ESCALATED on the edge where the timer reaches ESC_CYCLES-1 with no ack. With ack it moves to ACKED.
  - ESCALATED: moves to ACKED on ack. The timer holds.
  - ACKED: on each edge `latched[i]` clears for every channel with `alarm_leds[i]`=0. Moves to IDLE when `latched` becomes 0. Any new latch event moves it to ALERT with the timer cleared.
  - `latched` bits clear only in ACKED.
  - `ack` in IDLE is ignored.
- **Outputs.** `buzzer` and `escalate` are decoded from the state register only, with no combinational input path.

## Timing
- **Reset values.** All outputs and internal registers go to 0 immediately on reset assertion, independent of `clk`: `latched`=0, `buzzer`=0, `escalate`=0, `evt_valid`=0, `evt_chan`=0, `evt_pwr`=0, `alarm_count`=0, state=IDLE, all counters and the timer cleared.
- **Reset mid-operation.** Pending events are discarded and no partial transfer occurs.
- **Latch latency.** `alarm_leds[i]` going high before edge 1 and held through edge PERSIST gives `latched[i]`, `evt_valid`, and `buzzer` high after edge PERSIST.
- **Glitch.** A 0 sample at any edge restarts the count.
- **Escalation latency.** `escalate` rises ESC_CYCLES edges after the edge that entered ALERT.
- **Ack latency.** `ack` sampled high at edge N → `buzzer` and `escalate` are 0 after edge N.
- **Latch and ack on the same edge.** The latch wins: state ALERT with the timer cleared, and the ack is dropped.
- **Latch and transfer on the same edge.** The transfer clears its pend bit while the new pend bit is set. Both take effect, with no loss.
- **Release order in ACKED.** A raw bit still high keeps its `latched` bit. The block stays in ACKED until all raw bits drop.
- **Event throughput.** With `evt_ready` held at 1, one event transfers per edge.

## Test plan
1. **Glitch rejected.** PERSIST=3. `alarm_leds`=001 for 2 edges, then 000 → `latched`=000, `evt_valid`=0, `buzzer`=0, `alarm_count`=0.
2. **Latch and backpressure.** `alarm_leds`=010 held, `pwr_reg`=1010, `evt_ready`=0 → after edge 3: `latched`=010, `buzzer`=1, `evt_valid`=1, `evt_chan`=1, `evt_pwr`=1010. These stay stable for 5 more edges. Setting `evt_ready`=1 gives `evt_valid`=0 one edge later, and `alarm_count`=1.
3. **Escalation, ack, release.** After scenario 2, no ack → `escalate`=1 exactly 16 edges after the latch edge. Then:
   - `ack`=1 for one edge → `buzzer`=0 and `escalate`=0.
   - `alarm_leds`=000 → `latched`=000 and the state returns to IDLE.
4. **Simultaneous latches.** `alarm_leds`=111, `pwr_reg`=0101, `evt_ready`=1 → events on consecutive edges with `evt_chan` 0, 1, 2, all with `evt_pwr`=0101. Then `alarm_count`=3.
5. **Latch and ack on the same edge.** In ACKED with `latched`=001 and raw bit 0 still high, channel 2 qualifies on the same edge as `ack`=1 → state ALERT, `buzzer`=1, timer restarted. Then `escalate`=1 16 edges later.
6. **Reset mid-ESCALATED.** While `escalate`=1 with events pending, drive `rst_n`=1 between edges → all outputs 0 immediately. Releasing reset with `alarm_leds`=000 gives IDLE with no events.
